// File: rtl/spi_master_tx.sv
// spi_master_tx - byte-frame SPI master transmitter.
//
// Emits one frame per accepted start request: cs falls, then DATA_WIDTH+2
// sclk pulses (a lead pulse, DATA_WIDTH data pulses, a trail pulse), then cs
// rises together with a one-cycle done pulse. mosi is updated on rising sclk
// so it is stable at every falling edge, where the downstream slave samples.
//
// Ports:
//   clk   in   system clock, rising-edge logic
//   rst   in   asynchronous active-high reset
//   start in   frame request, honoured only while idle
//   din   in   DATA_WIDTH word, captured when start is accepted
//   sclk  out  SPI clock, idles low
//   mosi  out  serial data, MSB first
//   cs    out  active-low chip select, idles high
//   busy  out  high from start acceptance until done
//   done  out  one-cycle end-of-frame pulse
module spi_master_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs,
  output logic                  busy,
  output logic                  done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_WIDTH + 2);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [DIV_W-1:0]      div, div_nxt;
  logic [CNT_W-1:0]      pulse, pulse_nxt;
  logic                  sclk_nxt, mosi_nxt, cs_nxt, busy_nxt, done_nxt;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      div   <= '0;
      pulse <= '0;
      sclk  <= 1'b0;
      mosi  <= 1'b0;
      cs    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      div   <= div_nxt;
      pulse <= pulse_nxt;
      sclk  <= sclk_nxt;
      mosi  <= mosi_nxt;
      cs    <= cs_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    div_nxt   = div;
    pulse_nxt = pulse;
    sclk_nxt  = sclk;
    mosi_nxt  = mosi;
    cs_nxt    = cs;
    busy_nxt  = busy;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          // MSB is presented immediately so the lead falling edge sees it.
          shreg_nxt = din;
          mosi_nxt  = din[DATA_WIDTH-1];
          cs_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          div_nxt   = '0;
          pulse_nxt = '0;
          state_nxt = LEAD;
        end else begin
          state_nxt = IDLE;
        end
      end

      LEAD: begin
        // Low half-period before the lead pulse rises.
        if (div == DIV_LAST) begin
          div_nxt   = '0;
          sclk_nxt  = 1'b1;
          state_nxt = SHIFT;
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end

      SHIFT: begin
        if (div == DIV_LAST) begin
          div_nxt = '0;
          if (sclk) begin
            // Falling edge: pulse counter holds the number of completed falls.
            sclk_nxt = 1'b0;
            if (pulse == PULSE_LAST) begin
              state_nxt = TRAIL;
            end else begin
              pulse_nxt = pulse + CNT_W'(1);
            end
          end else begin
            // Rising edge of pulse k (k == pulse): data pulses shift out the
            // word, starting by re-presenting the MSB; trail pulse drives 0.
            sclk_nxt = 1'b1;
            if (pulse <= DATA_LAST) begin
              mosi_nxt  = shreg[DATA_WIDTH-1];
              shreg_nxt = shreg << 1;
            end else begin
              mosi_nxt = 1'b0;
            end
          end
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end

      TRAIL: begin
        // Hold sclk low one half-period after the trail pulse, then close.
        if (div == DIV_LAST) begin
          div_nxt   = '0;
          pulse_nxt = '0;
          cs_nxt    = 1'b1;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        div_nxt   = '0;
        pulse_nxt = '0;
        sclk_nxt  = 1'b0;
        mosi_nxt  = 1'b0;
        cs_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Testbench for spi_master_tx: two instances (CLK_DIV=2 and CLK_DIV=1), each
// with its own stimulus, cycle-level reference model and byte scoreboard.
module tb_spi_master_tx;

  localparam int DW = 8;

  logic clk = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int CD = (g == 0) ? 2 : 1;
    localparam int L  = CD * (2 * DW + 5);

    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] din   = '0;
    logic          sclk, mosi, cs, busy, done;
    bit            fin   = 1'b0;

    spi_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .din  (din),
      .sclk (sclk),
      .mosi (mosi),
      .cs   (cs),
      .busy (busy),
      .done (done)
    );

    // Reference model: frame timing derived from elapsed cycles since accept.
    logic [DW-1:0] expq[$];
    logic [DW-1:0] word = '0;
    int  rem = 0;
    logic m_cs = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_sclk = 1'b0, m_mosi = 1'b0;

    initial begin
      int e, p, k;
      forever begin
        @(posedge clk);
        if (rst) begin
          rem = 0;
          expq.delete();
          m_done = 1'b0;
        end else begin
          m_done = (rem == 1);
          if (rem > 0) rem--;
          else if (start) begin
            word = din;
            expq.push_back(din);
            rem = L;
          end
        end
        if (rem > 0) begin
          e = L - rem;
          p = e / CD;             // half-period index, 0 .. 2*DW+4
          m_cs   = 1'b0;
          m_busy = 1'b1;
          m_sclk = (p % 2 == 1) && (p <= 2 * DW + 3);
          k = (p == 0) ? 0 : (p - 1) / 2;   // pulse whose rise set mosi
          if (k == 0)       m_mosi = word[DW-1];
          else if (k <= DW) m_mosi = word[DW-k];
          else              m_mosi = 1'b0;
        end else begin
          m_cs = 1'b1; m_busy = 1'b0; m_sclk = 1'b0; m_mosi = 1'b0;
        end
      end
    end

    // Monitor: per-cycle output compare plus a negedge-sampling receiver.
    initial begin
      logic          p_cs = 1'b1, p_sclk = 1'b0, in_frame = 1'b0;
      int            cs_low = 0, falls = 0, rises = 0;
      logic [DW-1:0] recv = '0, exp_b;
      forever begin
        @(negedge clk);
        chk($sformatf("i%0d_cs", g),   cs,   m_cs);
        chk($sformatf("i%0d_busy", g), busy, m_busy);
        chk($sformatf("i%0d_done", g), done, m_done);
        chk($sformatf("i%0d_sclk", g), sclk, m_sclk);
        chk($sformatf("i%0d_mosi", g), mosi, m_mosi);
        if (rst) begin
          in_frame = 1'b0;
        end else begin
          if (p_cs && !cs) begin
            in_frame = 1'b1; cs_low = 0; falls = 0; rises = 0; recv = '0;
          end
          if (in_frame && !cs) begin
            cs_low++;
            if (!p_sclk && sclk) rises++;
            if (p_sclk && !sclk) begin
              if (falls >= 1 && falls <= DW) recv = {recv[DW-2:0], mosi};
              falls++;
            end
          end
          if (in_frame && cs) begin
            in_frame = 1'b0;
            chk($sformatf("i%0d_done_at_cs_rise", g), done, 1'b1);
            if (expq.size() == 0) begin
              chk($sformatf("i%0d_unexpected_frame", g), 32'd1, 32'd0);
            end else begin
              exp_b = expq.pop_front();
              chk($sformatf("i%0d_rx_byte", g), recv, exp_b);
            end
            chk($sformatf("i%0d_cs_low_cycles", g), cs_low, L);
            chk($sformatf("i%0d_rise_edges", g), rises, DW + 2);
            chk($sformatf("i%0d_fall_edges", g), falls, DW + 2);
          end
        end
        p_cs   = cs;
        p_sclk = sclk;
      end
    end

    task automatic step(input int n);
      repeat (n) @(negedge clk);
      #2;
    endtask

    task automatic check_idle(input string nm);
      chk($sformatf("i%0d_%s_cs", g, nm),   cs,   1'b1);
      chk($sformatf("i%0d_%s_sclk", g, nm), sclk, 1'b0);
      chk($sformatf("i%0d_%s_mosi", g, nm), mosi, 1'b0);
      chk($sformatf("i%0d_%s_busy", g, nm), busy, 1'b0);
      chk($sformatf("i%0d_%s_done", g, nm), done, 1'b0);
    endtask

    task automatic send(input logic [DW-1:0] w, input int gap);
      start = 1'b1;
      din   = w;
      step(1);
      start = 1'b0;
      din   = DW'($urandom);
      step(L + gap);
    endtask

    // Stimulus sequence for this instance.
    initial begin
      logic [DW-1:0] pats[4];
      pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h80; pats[3] = 8'h01;
      step(3);
      check_idle("reset");
      rst = 1'b0;
      step(2);
      if (g == 0) begin
        // reset while idle
        rst = 1'b1;
        #1 check_idle("rst_idle");
        step(2);
        rst = 1'b0;
        step(1);
        send(8'hA5, 3);
        // start while busy is ignored
        start = 1'b1; din = 8'hC3;
        step(1);
        start = 1'b0;
        step(10);
        start = 1'b1; din = 8'h3C;
        step(1);
        start = 1'b0;
        step(L);
        // back-to-back with start held high
        start = 1'b1; din = 8'h11;
        step(1);
        din = 8'h22;
        step(L + 2);
        start = 1'b0;
        step(L + 4);
        // din change right after acceptance
        start = 1'b1; din = 8'h5A;
        step(1);
        start = 1'b0; din = 8'hFF;
        step(L + 2);
        // reset during SHIFT pulse 4, then a clean frame
        start = 1'b1; din = 8'h96;
        step(1);
        start = 1'b0;
        step(CD * 9);
        rst = 1'b1;
        #1 check_idle("rst_mid");
        step(2);
        rst = 1'b0;
        step(3);
        send(8'h96, 2);
      end else begin
        for (int i = 0; i < 4; i++) send(pats[i], $urandom_range(0, 3));
      end
      for (int i = 0; i < 6; i++) send(DW'($urandom), $urandom_range(0, 3));
      step(L + 5);
      chk($sformatf("i%0d_queue_empty", g), expq.size(), 0);
      fin = 1'b1;
    end
  end

  // Wait for both instances, bounded, then report.
  initial begin
    int t = 0;
    while (!(inst[0].fin && inst[1].fin) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!(inst[0].fin && inst[1].fin)) chk("timeout", 32'd0, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
